// File: rtl/rbz_spi_pkg.sv
// Shared types and constants for the raybox-zero SPI register file.
// Holds defaults, FSM encoding and register indices; no logic.
package rbz_spi_pkg;

    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_CMD_W    = 4;
    localparam int DEF_DATA_W   = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } spi_state_t;

    // Register map as seen by the renderer/tracer
    localparam int REG_SKY    = 0;
    localparam int REG_FLOOR  = 1;
    localparam int REG_LEAK   = 2;
    localparam int REG_OTHER  = 3;
    localparam int REG_VSHIFT = 4;
    localparam int REG_VINF   = 5;
    localparam int REG_MAPD   = 6;
    localparam int REG_TEXADD = 7;

endpackage

// File: rtl/rbz_sync_edge.sv
// 2-FF synchroniser plus registered copy; level, rise and fall outputs.
// Latency: pad to level 2 clk, edge strobe acted on at 3rd clk; no backpressure.
module rbz_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta, sync, prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/rbz_spi_regfile.sv
// SPI-slave register file: frames stage per register, i_load commits staged values to o_regs.
// Latency: pad to stage 4 clk after last sclk rise, i_load to o_regs 1 clk; no backpressure.
module rbz_spi_regfile
    import rbz_spi_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int CMD_W    = DEF_CMD_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_reg_ss_n,
    input  logic                       i_reg_sclk,
    input  logic                       i_reg_mosi,
    input  logic                       i_load,
    output logic [NUM_REGS*DATA_W-1:0] o_regs,
    output logic [NUM_REGS-1:0]        o_pending,
    output logic                       o_commit,
    output logic                       o_bad_cmd
);

    localparam int FW    = CMD_W + DATA_W;
    localparam int CNT_W = $clog2(FW + 1);

    logic ss_lvl, ss_rise, ss_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    rbz_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .d(i_reg_ss_n),
        .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );
    rbz_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d(i_reg_sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    rbz_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d(i_reg_mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_edges;
    assign unused_edges = sclk_lvl ^ sclk_fall ^ mosi_rise ^ mosi_fall;

    spi_state_t          state, state_nxt;
    logic [FW-1:0]       shreg;
    logic [CNT_W-1:0]    cnt;
    logic [CMD_W-1:0]    cmd;
    logic [DATA_W-1:0]   data;
    logic                cmd_ok, last_bit;
    logic                frame_start, shift_en, wr_en, bad_en;
    logic [NUM_REGS-1:0] wr_mask, commit_mask, pending;
    logic [DATA_W-1:0]   staging [NUM_REGS];
    logic [DATA_W-1:0]   live    [NUM_REGS];

    assign cmd      = shreg[FW-1 -: CMD_W];
    assign data     = shreg[DATA_W-1:0];
    // Widened compare so NUM_REGS == 2**CMD_W still fits
    assign cmd_ok   = ({1'b0, cmd} < NUM_REGS[CMD_W:0]);
    assign last_bit = sclk_rise && (cnt == CNT_W'(FW - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ss_fall) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (ss_rise)       state_nxt = ST_IDLE;
                else if (last_bit) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_DRAIN;
            ST_DRAIN: if (ss_lvl) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_start = (state == ST_IDLE) && ss_fall;
        shift_en    = (state == ST_SHIFT) && sclk_rise && !ss_rise;
        wr_en       = (state == ST_DONE) && cmd_ok;
        bad_en      = (state == ST_DONE) && !cmd_ok;
        wr_mask     = '0;
        for (int n = 0; n < NUM_REGS; n++) begin
            wr_mask[n] = wr_en && (cmd == CMD_W'(n));
        end
        // A register written this cycle keeps its new value staged for the next strobe
        commit_mask = i_load ? (pending & ~wr_mask) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (frame_start) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (shift_en) begin
            shreg <= {shreg[FW-2:0], mosi_lvl};
            cnt   <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                staging[n] <= RESET_VAL[n*DATA_W +: DATA_W];
                live[n]    <= RESET_VAL[n*DATA_W +: DATA_W];
            end
            pending   <= '0;
            o_commit  <= 1'b0;
            o_bad_cmd <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_REGS; n++) begin
                if (wr_mask[n])     staging[n] <= data;
                if (commit_mask[n]) live[n]    <= staging[n];
            end
            pending   <= (pending & ~commit_mask) | wr_mask;
            o_commit  <= |commit_mask;
            o_bad_cmd <= o_bad_cmd | bad_en;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
        assign o_regs[gi*DATA_W +: DATA_W] = live[gi];
    end

    assign o_pending = pending;

endmodule

// File: tb/tb_rbz_spi_regfile.sv
// Scoreboarded bench for rbz_spi_regfile: SPI frames driven clock-aligned, commits checked as they appear.
module tb_rbz_spi_regfile;
    import rbz_spi_pkg::*;

    localparam int NR = 8;
    localparam int CW = 4;
    localparam int DW = 24;
    localparam int IW = NR * DW;
    localparam logic [IW-1:0] RV = {24'hAB0007, 24'hAB0006, 24'hAB0005, 24'hAB0004,
                                    24'hAB0003, 24'hAB0002, 24'hAB0001, 24'hAB0000};

    logic          clk = 1'b0;
    logic          reset_n, ss_n, sclk, mosi, i_load;
    logic [IW-1:0] o_regs;
    logic [NR-1:0] o_pending;
    logic          o_commit, o_bad_cmd;

    rbz_spi_regfile #(
        .NUM_REGS(NR), .CMD_W(CW), .DATA_W(DW), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_reg_ss_n(ss_n), .i_reg_sclk(sclk), .i_reg_mosi(mosi),
        .i_load(i_load),
        .o_regs(o_regs), .o_pending(o_pending),
        .o_commit(o_commit), .o_bad_cmd(o_bad_cmd)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [IW-1:0] sb_q [$];
    logic [DW-1:0] m_live  [NR];
    logic [DW-1:0] m_stage [NR];
    logic [NR-1:0] m_pend;
    logic          m_bad;

    task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] model_image();
        logic [IW-1:0] img;
        for (int n = 0; n < NR; n++) img[n*DW +: DW] = m_live[n];
        return img;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NR; n++) begin
            m_live[n]  = RV[n*DW +: DW];
            m_stage[n] = RV[n*DW +: DW];
        end
        m_pend = '0;
        m_bad  = 1'b0;
    endtask

    task automatic model_load(input logic [NR-1:0] excl, output logic fired);
        logic [NR-1:0] c;
        c = m_pend & ~excl;
        for (int n = 0; n < NR; n++) if (c[n]) m_live[n] = m_stage[n];
        m_pend = m_pend & ~c;
        fired  = (c != '0);
        if (fired) sb_q.push_back(model_image());
    endtask

    // Every o_commit pulse must match the oldest expected commit image
    always @(negedge clk) begin
        if (reset_n === 1'b1 && o_commit === 1'b1) begin
            if (sb_q.size() == 0) chk("commit_unexpected", IW'(o_commit), '0);
            else                  chk("commit_image", o_regs, sb_q.pop_front());
        end
    end

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "_regs"}, o_regs, model_image());
        chk({tag, "_pend"}, IW'(o_pending), IW'(m_pend));
        chk({tag, "_bad"},  IW'(o_bad_cmd), IW'(m_bad));
    endtask

    // Drives bits[nbits-1:0] MSB first; optional i_load lands on the DONE cycle of the last bit
    task automatic spi_frame(input logic [63:0] bits, input int nbits, input bit collide);
        @(posedge clk); #1 ss_n = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            #1 mosi = bits[i];
            repeat (4) @(posedge clk);
            #1 sclk = 1'b1;
            if (collide && i == 0) begin
                repeat (3) @(posedge clk);
                #1 i_load = 1'b1;
                @(posedge clk);
                #1 i_load = 1'b0;
            end else begin
                repeat (4) @(posedge clk);
            end
            #1 sclk = 1'b0;
            repeat (4) @(posedge clk);
        end
        #1 ss_n = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic send(input logic [CW-1:0] cmd, input logic [DW-1:0] data,
                        input int extra, input bit collide);
        logic [63:0] b;
        logic        fired;
        b = {36'b0, cmd, data};
        b = (b << extra) | (64'hA5A & ((64'h1 << extra) - 64'h1));
        if (collide) model_load(NR'(1) << cmd, fired);
        if (int'(cmd) < NR) begin
            m_stage[cmd[2:0]] = data;
            m_pend[cmd[2:0]]  = 1'b1;
        end else begin
            m_bad = 1'b1;
        end
        spi_frame(b, CW + DW + extra, collide);
    endtask

    task automatic do_load(input string tag);
        logic fired;
        model_load('0, fired);
        @(posedge clk); #1 i_load = 1'b1;
        @(posedge clk); #1 i_load = 1'b0;
        @(negedge clk);
        chk({tag, "_commit"}, IW'(o_commit), IW'(fired));
        chk({tag, "_pend"},   IW'(o_pending), IW'(m_pend));
        @(negedge clk);
        chk({tag, "_commit_width"}, IW'(o_commit), '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] raw;
        reset_n = 1'b0; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; i_load = 1'b0;
        model_reset();

        // T1 reset
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check_state("t1");
        chk("t1_commit", IW'(o_commit), '0);

        // T2 write then commit
        send(4'd3, 24'h123456, 0, 1'b0);
        check_state("t2_staged");
        do_load("t2_load");
        check_state("t2_live");

        // T3 short frame ignored, long frame truncated
        raw = {44'b0, 4'h1, 16'hBEEF};
        spi_frame(raw, 20, 1'b0);
        check_state("t3_short");
        send(4'd2, 24'hFFFFFF, 12, 1'b0);
        check_state("t3_long");
        do_load("t3_load");
        check_state("t3_live");

        // T4 bad command is sticky and writes nothing
        send(4'd9, 24'h777777, 0, 1'b0);
        check_state("t4_bad");
        send(4'd6, 24'h0A0B0C, 0, 1'b0);
        check_state("t4_sticky");
        do_load("t4_load");

        // T5 i_load coincident with DONE on reg5
        send(4'd0, 24'h00C0DE, 0, 1'b0);
        check_state("t5_pre");
        send(4'd5, 24'h55AA55, 0, 1'b1);
        check_state("t5_collide");
        do_load("t5_load2");
        check_state("t5_live");

        // T6 reset in the middle of a frame
        raw = {36'b0, 4'h4, 24'h987654};
        @(posedge clk); #1 ss_n = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = 27; i > 17; i--) begin
            #1 mosi = raw[i];
            repeat (4) @(posedge clk);
            #1 sclk = 1'b1;
            repeat (4) @(posedge clk);
            #1 sclk = 1'b0;
            repeat (4) @(posedge clk);
        end
        #1 reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        ss_n = 1'b1;
        repeat (8) @(posedge clk);
        check_state("t6_reset");
        chk("t6_commit", IW'(o_commit), '0);
        send(4'd4, 24'h444444, 0, 1'b0);
        check_state("t6_staged");
        do_load("t6_load");
        check_state("t6_live");

        repeat (4) @(posedge clk);
        chk("sb_drained", IW'(sb_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
